// File: rtl/led_rate_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : led_rate_decoder
// Description : Receive side of the LED blinker. Measures the half-period of
//               the sensed LED drive, classifies it as 100/50/10/1 Hz and
//               reconstructs the 2-bit switch code that produced it.
// Ports       : i_clock        system clock
//               i_reset        asynchronous active-high reset
//               i_led_sense    LED drive under test (asynchronous)
//               o_active       line toggling (edge seen, no timeout since)
//               o_locked       a rate code is confirmed
//               o_switch_1/2   decoded switch code {switch_1, switch_2}
//               o_update       one-cycle pulse when a new code is locked
//               o_half_period  last measured half-period in clocks
// Revision    : 1.0 - initial release
// ============================================================================
module led_rate_decoder #(
  parameter int CLK_HZ         = 25000000,
  parameter int TOL_SHIFT      = 4,
  parameter int CONFIRM        = 4,
  parameter int TIMEOUT_CYCLES = 25000000,
  parameter int CNT_W          = 25
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_led_sense,
  output logic             o_active,
  output logic             o_locked,
  output logic             o_switch_1,
  output logic             o_switch_2,
  output logic             o_update,
  output logic [CNT_W-1:0] o_half_period
);

  localparam int MW = $clog2(CONFIRM + 1);

  localparam logic [CNT_W-1:0] c_nom_100 = CNT_W'(CLK_HZ / 200);
  localparam logic [CNT_W-1:0] c_nom_50  = CNT_W'(CLK_HZ / 100);
  localparam logic [CNT_W-1:0] c_nom_10  = CNT_W'(CLK_HZ / 20);
  localparam logic [CNT_W-1:0] c_nom_1   = CNT_W'(CLK_HZ / 2);
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [MW-1:0]    c_confirm = MW'(CONFIRM);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t           r_state, w_state_next;
  logic             r_sync1, r_sync2, r_prev;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [CNT_W-1:0] r_half, w_half_next;
  logic             r_cand_hit, w_cand_hit_next;
  logic [1:0]       r_cand_code, w_cand_code_next;
  logic [MW-1:0]    r_match, w_match_next;
  logic             r_active, w_active_next;
  logic             r_locked, w_locked_next;
  logic [1:0]       r_code, w_code_next;
  logic             r_update, w_update_next;

  logic             w_edge;
  logic [CNT_W-1:0] w_meas;
  logic             w_cls_hit;
  logic [1:0]       w_cls_code;

  // Inclusive window test: |m - nom| <= nom >> TOL_SHIFT
  function automatic logic in_window(input logic [CNT_W-1:0] m,
                                     input logic [CNT_W-1:0] nom);
    logic [CNT_W-1:0] tol;
    tol = nom >> TOL_SHIFT;
    return (m >= (nom - tol)) && (m <= (nom + tol));
  endfunction

  // Either polarity of transition on the synchronized line is an edge
  assign w_edge = r_sync2 ^ r_prev;
  // Counter was cleared in the previous edge cycle, so +1 gives the exact
  // number of clocks between edges
  assign w_meas = r_cnt + CNT_W'(1);

  // A miss reports code 00 so candidate comparison can use plain equality
  always_comb begin
    w_cls_hit  = 1'b1;
    w_cls_code = 2'b00;
    if (in_window(w_meas, c_nom_100)) begin
      w_cls_code = 2'b00;
    end else if (in_window(w_meas, c_nom_50)) begin
      w_cls_code = 2'b01;
    end else if (in_window(w_meas, c_nom_10)) begin
      w_cls_code = 2'b10;
    end else if (in_window(w_meas, c_nom_1)) begin
      w_cls_code = 2'b11;
    end else begin
      w_cls_hit  = 1'b0;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_half_next      = r_half;
    w_cand_hit_next  = r_cand_hit;
    w_cand_code_next = r_cand_code;
    w_match_next     = r_match;
    w_active_next    = r_active;
    w_locked_next    = r_locked;
    w_code_next      = r_code;
    w_update_next    = 1'b0;

    if (w_edge) begin
      w_cnt_next = '0;
    end else if (r_cnt != c_cnt_max) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end else begin
      w_cnt_next = r_cnt;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_edge) begin
          w_state_next  = ST_MEASURE;
          w_active_next = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (w_edge) begin
          w_half_next      = w_meas;
          w_cand_hit_next  = w_cls_hit;
          w_cand_code_next = w_cls_code;
          if ((w_cls_hit == r_cand_hit) && (w_cls_code == r_cand_code)) begin
            w_match_next = (r_match == c_confirm) ? r_match : r_match + MW'(1);
          end else begin
            w_match_next = MW'(1);
          end
          if (w_match_next == c_confirm) begin
            if (w_cls_hit) begin
              if (!r_locked || (w_cls_code != r_code)) begin
                w_code_next   = w_cls_code;
                w_locked_next = 1'b1;
                w_update_next = 1'b1;
              end
            end else begin
              w_locked_next = 1'b0;
            end
          end
        end else if (r_cnt == c_cnt_max) begin
          // Edge takes priority over timeout, handled by the branch above
          w_state_next  = ST_IDLE;
          w_active_next = 1'b0;
          w_locked_next = 1'b0;
          w_code_next   = 2'b00;
          w_match_next  = '0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_prev      <= 1'b0;
      r_cnt       <= '0;
      r_half      <= '0;
      r_cand_hit  <= 1'b0;
      r_cand_code <= 2'b00;
      r_match     <= '0;
      r_active    <= 1'b0;
      r_locked    <= 1'b0;
      r_code      <= 2'b00;
      r_update    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_sync1     <= i_led_sense;
      r_sync2     <= r_sync1;
      r_prev      <= r_sync2;
      r_cnt       <= w_cnt_next;
      r_half      <= w_half_next;
      r_cand_hit  <= w_cand_hit_next;
      r_cand_code <= w_cand_code_next;
      r_match     <= w_match_next;
      r_active    <= w_active_next;
      r_locked    <= w_locked_next;
      r_code      <= w_code_next;
      r_update    <= w_update_next;
    end
  end

  assign o_active      = r_active;
  assign o_locked      = r_locked;
  assign o_switch_1    = r_code[1];
  assign o_switch_2    = r_code[0];
  assign o_update      = r_update;
  assign o_half_period = r_half;

endmodule
`default_nettype wire

// File: tb/tb_led_rate_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_led_rate_decoder
// Description : Self-checking bench for led_rate_decoder, scaled clock so the
//               four rates have nominal half-periods 20/40/200/2000 clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_rate_decoder;

  localparam int CLK_HZ    = 4000;
  localparam int TOL_SHIFT = 4;
  localparam int CONFIRM   = 4;
  localparam int TIMEOUT   = 5000;
  localparam int CNT_W     = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             led = 1'b0;
  logic             o_active, o_locked, o_switch_1, o_switch_2, o_update;
  logic [CNT_W-1:0] o_half_period;

  always #5 clk = ~clk;

  led_rate_decoder #(
    .CLK_HZ(CLK_HZ), .TOL_SHIFT(TOL_SHIFT), .CONFIRM(CONFIRM),
    .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_led_sense(led),
    .o_active(o_active), .o_locked(o_locked),
    .o_switch_1(o_switch_1), .o_switch_2(o_switch_2),
    .o_update(o_update), .o_half_period(o_half_period)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int code; int hp; } exp_t;
  exp_t exp_q[$];

  // Reference model state
  bit m_active = 1'b0;
  bit m_locked = 1'b0;
  int m_code   = 0;
  int m_hp     = 0;
  int hist[$];
  int gap      = 0;

  function automatic int nominal(input int k);
    int rates[4] = '{100, 50, 10, 1};
    return CLK_HZ / (2 * rates[k]);
  endfunction

  // Returns the code index whose window contains m, or -1
  function automatic int classify(input int m);
    for (int k = 0; k < 4; k++) begin
      int nom, tol, diff;
      nom  = nominal(k);
      tol  = nom >> TOL_SHIFT;
      diff = (m > nom) ? m - nom : nom - m;
      if (diff <= tol) return k;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_locked = 1'b0; m_code = 0; m_hp = 0;
    hist.delete();
  endtask

  task automatic model_timeout();
    m_active = 1'b0; m_locked = 1'b0; m_code = 0;
    hist.delete();
  endtask

  // A lock decision is taken when the last CONFIRM measurements agree
  task automatic model_edge(input int g);
    int c;
    bit same;
    exp_t e;
    if (m_active && g > TIMEOUT) model_timeout();
    if (!m_active) begin
      m_active = 1'b1;
      return;
    end
    m_hp = g;
    hist.push_back(classify(g));
    if (hist.size() > CONFIRM) void'(hist.pop_front());
    if (hist.size() == CONFIRM) begin
      c = hist[0];
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != c) same = 1'b0;
      if (same) begin
        if (c >= 0) begin
          if (!m_locked || c != m_code) begin
            e.code = c; e.hp = g;
            exp_q.push_back(e);
          end
          m_locked = 1'b1;
          m_code   = c;
        end else begin
          m_locked = 1'b0;
        end
      end
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " active"}, o_active, m_active);
    check({tag, " locked"}, o_locked, m_locked);
    check({tag, " code"}, {o_switch_1, o_switch_2}, m_code);
    check({tag, " half_period"}, o_half_period, m_hp);
  endtask

  // Toggle the line, then hold it for h clocks
  task automatic hp(input int h);
    led = ~led;
    model_edge(gap);
    gap = 0;
    for (int i = 1; i <= h; i++) begin
      @(negedge clk);
      gap++;
      if (i == 3) check_state("edge");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      gap++;
    end
    if (m_active && gap > TIMEOUT + 2) model_timeout();
    check_state("idle");
  endtask

  // Monitor: every o_update pulse must match the next expected lock event
  always @(negedge clk) begin
    exp_t e;
    if (o_update) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_update: got o_update=1, required 0 (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("update code", {o_switch_1, o_switch_2}, e.code);
        check("update half_period", o_half_period, e.hp);
      end
    end
  end

  initial begin
    int k, run, nom, tol, h;
    repeat (3) @(negedge clk);
    check_state("reset");
    check("reset update", o_update, 0);
    rst = 1'b0;
    gap = 0;

    // 100 Hz lock
    repeat (6) hp(20);
    // 50 Hz lock, then rate change to 1 Hz
    repeat (6) hp(40);
    repeat (5) hp(2000);
    // Tolerance boundary at 10 Hz (nominal 200, tolerance 12)
    repeat (6) hp(212);
    repeat (6) hp(213);
    repeat (6) hp(188);
    repeat (5) hp(187);
    // Outlier while locked at 10 Hz
    repeat (6) hp(200);
    hp(800);
    repeat (5) hp(200);
    // Edge exactly at the timeout count is still an edge
    hp(TIMEOUT);
    repeat (3) hp(200);
    // Timeout after lock at 50 Hz, then resume 100 Hz
    repeat (6) hp(40);
    idle(TIMEOUT + 10);
    repeat (6) hp(20);
    // Asynchronous reset between clock edges while locked
    repeat (6) hp(200);
    @(negedge clk);
    #2;
    rst = 1'b1;
    led = 1'b0;
    model_reset();
    #1;
    check_state("async reset");
    check("async reset update", o_update, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    gap = 0;
    repeat (6) hp(40);

    // Randomized runs around all four windows
    for (int r = 0; r < 20; r++) begin
      k   = $urandom_range(0, 3);
      run = $urandom_range(1, 5);
      nom = nominal(k);
      tol = nom >> TOL_SHIFT;
      for (int j = 0; j < run; j++) begin
        h = nom + $urandom_range(0, 2 * tol + 4) - (tol + 2);
        if (h < 4) h = 4;
        hp(h);
      end
    end

    repeat (10) @(negedge clk);
    check("pending updates", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
